// File: rtl/uart_kernel_nios2_cpu_div_cell_if.sv
// Divider operand/result bundle: E-stage operands and controls in, M-stage busy/done/results out.
// Handshake is a start pulse; no backpressure, the pipeline stalls on M_div_busy.
interface uart_kernel_nios2_cpu_div_cell_if #(
  parameter int DIV_WIDTH = 32
);
  logic [DIV_WIDTH-1:0] E_src1;
  logic [DIV_WIDTH-1:0] E_src2;
  logic                 E_div_start;
  logic                 E_div_signed;
  logic                 E_div_kill;
  logic                 M_div_busy;
  logic                 M_div_done;
  logic [DIV_WIDTH-1:0] M_div_quot;
  logic [DIV_WIDTH-1:0] M_div_rem;

  modport master (
    output E_src1, E_src2, E_div_start, E_div_signed, E_div_kill,
    input  M_div_busy, M_div_done, M_div_quot, M_div_rem
  );

  modport slave (
    input  E_src1, E_src2, E_div_start, E_div_signed, E_div_kill,
    output M_div_busy, M_div_done, M_div_quot, M_div_rem
  );
endinterface

// File: rtl/uart_kernel_nios2_cpu_div_cell.sv
// Radix-2 restoring div/divu, 35 cycles start-to-done; starts while busy are dropped, kill aborts silently.
// Signed div support is built only when UART_KERNEL_DIV_SIGNED_EN is defined; otherwise all ops are divu.
module uart_kernel_nios2_cpu_div_cell #(
  parameter int DIV_WIDTH = 32,
  parameter int CNT_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  uart_kernel_nios2_cpu_div_cell_if.slave bus
);
  localparam int W = DIV_WIDTH;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         dvd_q, dvd_d;
  logic [W:0]           dvs_q, dvs_d;
  logic [W-1:0]         rem_q, rem_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         quot_out_q, quot_out_d;
  logic [W-1:0]         rem_out_q, rem_out_d;
  logic                 done_q, done_d;

  // Partial remainder stays below the divisor magnitude, so W bits hold it; only the trial is W+1.
  logic [W:0]           rem_shift;
  logic [W:0]           trial;
  logic                 trial_ge;

  assign rem_shift = {rem_q, dvd_q[W-1]};
  assign trial     = rem_shift - dvs_q;
  assign trial_ge  = (rem_shift >= dvs_q);

`ifdef UART_KERNEL_DIV_SIGNED_EN
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;
`else
  logic unused_signed;
  assign unused_signed = bus.E_div_signed;
`endif

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    done_d     = 1'b0;
`ifdef UART_KERNEL_DIV_SIGNED_EN
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.E_div_start && !bus.E_div_kill) begin
          state_d = PREP;
          dvd_d   = bus.E_src1;
          dvs_d   = {1'b0, bus.E_src2};
`ifdef UART_KERNEL_DIV_SIGNED_EN
          q_neg_d = bus.E_div_signed & (bus.E_src1[W-1] ^ bus.E_src2[W-1]);
          r_neg_d = bus.E_div_signed & bus.E_src1[W-1];
`endif
        end
      end
      PREP: begin
`ifdef UART_KERNEL_DIV_SIGNED_EN
        // Divisor sign is recovered as q_neg ^ r_neg; 0x80000000 negates to itself, a valid magnitude.
        if (r_neg_q) begin
          dvd_d = -dvd_q;
        end
        if (q_neg_q ^ r_neg_q) begin
          dvs_d = {1'b0, -dvs_q[W-1:0]};
        end
`endif
        rem_d   = '0;
        cnt_d   = CNT_WIDTH'(DIV_WIDTH - 1);
        state_d = ITER;
      end
      ITER: begin
        if (trial_ge) begin
          rem_d = W'(trial);
          dvd_d = {dvd_q[W-2:0], 1'b1};
        end else begin
          rem_d = W'(rem_shift);
          dvd_d = {dvd_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
`ifdef UART_KERNEL_DIV_SIGNED_EN
        quot_out_d = q_neg_q ? -dvd_q : dvd_q;
        rem_out_d  = r_neg_q ? -rem_q : rem_q;
`else
        quot_out_d = dvd_q;
        rem_out_d  = rem_q;
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush abandons the op in flight, including one about to complete in FIX.
    if (bus.E_div_kill && (state_q != IDLE)) begin
      state_d    = IDLE;
      done_d     = 1'b0;
      quot_out_d = quot_out_q;
      rem_out_d  = rem_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      done_q     <= 1'b0;
`ifdef UART_KERNEL_DIV_SIGNED_EN
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      done_q     <= done_d;
`ifdef UART_KERNEL_DIV_SIGNED_EN
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
`endif
    end
  end

  assign bus.M_div_busy = (state_q != IDLE);
  assign bus.M_div_done = done_q;
  assign bus.M_div_quot = quot_out_q;
  assign bus.M_div_rem  = rem_out_q;
endmodule
